// File: rtl/exu_mc.sv
// exu_mc - multi-cycle RV32I execute unit.
//
// Executes LUI, OP-IMM and OP directly into an internal register file in one
// cycle. Issues LOAD/STORE over a valid/ready memory channel, with alignment
// checking, byte-lane steering and a response timeout. Every accepted
// instruction produces exactly one registered done pulse. A reset that lands
// mid-operation drops that operation without a done pulse.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   iexec_req_vld/rdy/ir    instruction handshake and raw instruction word
//   done_vld/done_err       completion pulse; 0 ok, 1 illegal, 2 misaligned, 3 timeout
//   ldst_req_*              memory request: word address, we, lane data, strobes
//   ldst_rsp_vld/rdy/data   memory response (rdy tied high)
//   dbg_rf_idx/dbg_rf_data  combinational register-file debug read
module exu_mc #(
  parameter int RF_DEPTH   = 32,
  parameter int LS_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iexec_req_vld,
  output logic        iexec_req_rdy,
  input  logic [31:0] iexec_req_ir,
  output logic        done_vld,
  output logic [1:0]  done_err,
  output logic        ldst_req_vld,
  input  logic        ldst_req_rdy,
  output logic [31:0] ldst_req_addr,
  output logic        ldst_req_we,
  output logic [31:0] ldst_req_wdata,
  output logic [3:0]  ldst_req_strb,
  input  logic        ldst_rsp_vld,
  output logic        ldst_rsp_rdy,
  input  logic [31:0] ldst_rsp_data,
  input  logic [4:0]  dbg_rf_idx,
  output logic [31:0] dbg_rf_data
);

  localparam int          AW      = $clog2(RF_DEPTH);
  localparam logic [5:0]  DEPTH_W = 6'(RF_DEPTH);
  localparam logic [31:0] TO_LAST = 32'(LS_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LS_REQ = 2'd1;
  localparam logic [1:0] ST_LS_RSP = 2'd2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic [1:0]  state_q, state_d;
  logic [31:0] rf_q [RF_DEPTH];
  logic [31:0] rf_d [RF_DEPTH];
  logic        done_vld_q, done_vld_d;
  logic [1:0]  done_err_q, done_err_d;
  logic        req_vld_q, req_vld_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_we_q, req_we_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_strb_q, req_strb_d;
  logic [1:0]  ea_lo_q, ea_lo_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] cnt_q, cnt_d;

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [2:0]  f3;
  logic [31:0] rs1_val, rs2_val, imm_i, imm_s, op_b, alu_res, ea;
  logic [31:0] st_wdata, ld_shift, ld_val;
  logic [3:0]  st_strb;
  logic        legal, is_alu, misaligned;

  function automatic logic idx_ok(input logic [4:0] idx);
    return {1'b0, idx} < DEPTH_W;
  endfunction

  assign iexec_req_rdy  = (state_q == ST_IDLE) & rst_n;
  assign done_vld       = done_vld_q;
  assign done_err       = done_err_q;
  assign ldst_req_vld   = req_vld_q;
  assign ldst_req_addr  = req_addr_q;
  assign ldst_req_we    = req_we_q;
  assign ldst_req_wdata = req_wdata_q;
  assign ldst_req_strb  = req_strb_q;
  assign ldst_rsp_rdy   = 1'b1;

  // Register-file reads; x0 and out-of-range indices read as zero.
  always_comb begin
    rs1_val     = '0;
    rs2_val     = '0;
    dbg_rf_data = '0;
    if (rs1 != 5'd0 && idx_ok(rs1)) rs1_val = rf_q[rs1[AW-1:0]];
    if (rs2 != 5'd0 && idx_ok(rs2)) rs2_val = rf_q[rs2[AW-1:0]];
    if (dbg_rf_idx != 5'd0 && idx_ok(dbg_rf_idx)) dbg_rf_data = rf_q[dbg_rf_idx[AW-1:0]];
  end

  // Instruction decode, ALU, legality, effective address and store lanes.
  always_comb begin
    opcode = iexec_req_ir[6:0];
    rd     = iexec_req_ir[11:7];
    f3     = iexec_req_ir[14:12];
    rs1    = iexec_req_ir[19:15];
    rs2    = iexec_req_ir[24:20];
    f7     = iexec_req_ir[31:25];
    imm_i  = {{20{iexec_req_ir[31]}}, iexec_req_ir[31:20]};
    imm_s  = {{20{iexec_req_ir[31]}}, iexec_req_ir[31:25], iexec_req_ir[11:7]};
    op_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    shamt  = op_b[4:0];

    alu_res = '0;
    case (f3)
      3'd0: alu_res = (opcode == OPC_OP && iexec_req_ir[30]) ? rs1_val - op_b : rs1_val + op_b;
      3'd1: alu_res = rs1_val << shamt;
      3'd2: alu_res = {31'd0, $signed(rs1_val) < $signed(op_b)};
      3'd3: alu_res = {31'd0, rs1_val < op_b};
      3'd4: alu_res = rs1_val ^ op_b;
      // Arithmetic shift kept in its own branch so the signed operand is not
      // turned unsigned by a mixed-sign conditional expression.
      3'd5: begin
        if (iexec_req_ir[30]) alu_res = $signed(rs1_val) >>> shamt;
        else                  alu_res = rs1_val >> shamt;
      end
      3'd6: alu_res = rs1_val | op_b;
      default: alu_res = rs1_val & op_b;
    endcase
    if (opcode == OPC_LUI) alu_res = {iexec_req_ir[31:12], 12'd0};

    legal  = 1'b0;
    is_alu = 1'b0;
    case (opcode)
      OPC_LUI: begin
        is_alu = 1'b1;
        legal  = idx_ok(rd);
      end
      OPC_OP_IMM: begin
        is_alu = 1'b1;
        legal  = idx_ok(rd) && idx_ok(rs1);
        if (f3 == 3'd1) legal = legal && (f7 == 7'd0);
        if (f3 == 3'd5) legal = legal && (f7 == 7'd0 || f7 == 7'b0100000);
      end
      OPC_OP: begin
        is_alu = 1'b1;
        legal  = idx_ok(rd) && idx_ok(rs1) && idx_ok(rs2) &&
                 (f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OPC_LOAD:  legal = idx_ok(rd) && idx_ok(rs1) && f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7;
      OPC_STORE: legal = idx_ok(rs1) && idx_ok(rs2) && f3 <= 3'd2;
      default:   legal = 1'b0;
    endcase

    ea         = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    misaligned = (f3[1:0] == 2'b01 && ea[0]) || (f3[1:0] == 2'b10 && ea[1:0] != 2'b00);

    st_wdata = '0;
    st_strb  = '0;
    if (opcode == OPC_STORE) begin
      case (f3[1:0])
        2'd0: begin
          st_wdata = {4{rs2_val[7:0]}};
          st_strb  = 4'b0001 << ea[1:0];
        end
        2'd1: begin
          st_wdata = {2{rs2_val[15:0]}};
          st_strb  = ea[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          st_wdata = rs2_val;
          st_strb  = 4'b1111;
        end
      endcase
    end
  end

  // Load lane extraction from the latched low address bits and funct3.
  always_comb begin
    ld_shift = ldst_rsp_data >> {ea_lo_q, 3'b000};
    case (f3_q)
      3'd0:    ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'd1:    ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'd4:    ld_val = {24'd0, ld_shift[7:0]};
      3'd5:    ld_val = {16'd0, ld_shift[15:0]};
      default: ld_val = ld_shift;
    endcase
  end

  // Next-state logic for the FSM, register file, payload and done pulse.
  always_comb begin
    state_d     = state_q;
    rf_d        = rf_q;
    done_vld_d  = 1'b0;
    done_err_d  = 2'd0;
    req_vld_d   = req_vld_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    req_strb_d  = req_strb_q;
    ea_lo_d     = ea_lo_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (iexec_req_vld && iexec_req_rdy) begin
          done_vld_d = 1'b1;
          if (!legal) begin
            done_err_d = 2'd1;
          end else if (is_alu) begin
            if (rd != 5'd0) rf_d[rd[AW-1:0]] = alu_res;
          end else if (misaligned) begin
            done_err_d = 2'd2;
          end else begin
            // Memory op: completion is reported later, from LS_RSP.
            done_vld_d  = 1'b0;
            req_vld_d   = 1'b1;
            req_addr_d  = {ea[31:2], 2'b00};
            req_we_d    = (opcode == OPC_STORE);
            req_wdata_d = st_wdata;
            req_strb_d  = st_strb;
            ea_lo_d     = ea[1:0];
            f3_d        = f3;
            rd_d        = rd;
            state_d     = ST_LS_REQ;
          end
        end
      end
      ST_LS_REQ: begin
        if (ldst_req_rdy) begin
          req_vld_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_LS_RSP;
        end
      end
      ST_LS_RSP: begin
        // A response wins over the timeout in the same cycle.
        if (ldst_rsp_vld) begin
          if (!req_we_q && rd_q != 5'd0) rf_d[rd_q[AW-1:0]] = ld_val;
          done_vld_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (LS_TIMEOUT != 0 && cnt_q == TO_LAST) begin
          done_vld_d = 1'b1;
          done_err_d = 2'd3;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      done_vld_q  <= 1'b0;
      done_err_q  <= 2'd0;
      req_vld_q   <= 1'b0;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      req_strb_q  <= '0;
      ea_lo_q     <= '0;
      f3_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      done_vld_q  <= done_vld_d;
      done_err_q  <= done_err_d;
      req_vld_q   <= req_vld_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      req_strb_q  <= req_strb_d;
      ea_lo_q     <= ea_lo_d;
      f3_q        <= f3_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      rf_q        <= rf_d;
    end
  end

endmodule

// File: tb/tb_exu_mc.sv
// tb_exu_mc - self-checking bench for exu_mc (RF_DEPTH=16, LS_TIMEOUT=4).
// Table-driven ALU/illegal/misaligned vectors plus directed load/store,
// timeout and reset sequences. Expected values are hand-computed.
module tb_exu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iexec_req_vld;
  logic        iexec_req_rdy;
  logic [31:0] iexec_req_ir;
  logic        done_vld;
  logic [1:0]  done_err;
  logic        ldst_req_vld;
  logic        ldst_req_rdy;
  logic [31:0] ldst_req_addr;
  logic        ldst_req_we;
  logic [31:0] ldst_req_wdata;
  logic [3:0]  ldst_req_strb;
  logic        ldst_rsp_vld;
  logic        ldst_rsp_rdy;
  logic [31:0] ldst_rsp_data;
  logic [4:0]  dbg_rf_idx;
  logic [31:0] dbg_rf_data;

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] LDO = 7'b0000011;

  always #5 clk = ~clk;

  exu_mc #(.RF_DEPTH(16), .LS_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .iexec_req_vld(iexec_req_vld), .iexec_req_rdy(iexec_req_rdy), .iexec_req_ir(iexec_req_ir),
    .done_vld(done_vld), .done_err(done_err),
    .ldst_req_vld(ldst_req_vld), .ldst_req_rdy(ldst_req_rdy), .ldst_req_addr(ldst_req_addr),
    .ldst_req_we(ldst_req_we), .ldst_req_wdata(ldst_req_wdata), .ldst_req_strb(ldst_req_strb),
    .ldst_rsp_vld(ldst_rsp_vld), .ldst_rsp_rdy(ldst_rsp_rdy), .ldst_rsp_data(ldst_rsp_data),
    .dbg_rf_idx(dbg_rf_idx), .dbg_rf_data(dbg_rf_data)
  );

  typedef struct {
    logic [31:0] ir;
    logic [1:0]  err;
    logic [4:0]  idx;
    logic [31:0] val;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] encU(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [31:0] ir, input logic [1:0] err, input logic [4:0] idx,
                        input logic [31:0] val);
    vec_t v;
    v.ir = ir; v.err = err; v.idx = idx; v.val = val;
    vecs.push_back(v);
  endtask

  // Present one instruction for exactly one accept edge; returns #1 after it.
  task automatic applyStimulus(input logic [31:0] ir);
    iexec_req_vld = 1'b1;
    iexec_req_ir  = ir;
    checkOutput("iexec_req_rdy before issue", iexec_req_rdy, 1);
    @(posedge clk); #1;
    iexec_req_vld = 1'b0;
  endtask

  task automatic checkReg(input string name, input logic [4:0] idx, input logic [31:0] exp);
    dbg_rf_idx = idx;
    #1;
    checkOutput(name, dbg_rf_data, exp);
  endtask

  // Zero-wait load: request accepted on the first edge, response on the next.
  task automatic doLoad(input string name, input logic [31:0] ir, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd, input logic [31:0] exp);
    applyStimulus(ir);
    checkOutput({name, " req_vld"}, ldst_req_vld, 1);
    checkOutput({name, " addr"}, ldst_req_addr, addr);
    checkOutput({name, " we"}, ldst_req_we, 0);
    checkOutput({name, " strb"}, ldst_req_strb, 0);
    checkOutput({name, " rdy busy"}, iexec_req_rdy, 0);
    @(posedge clk); #1;
    checkOutput({name, " no early done"}, done_vld, 0);
    ldst_rsp_vld  = 1'b1;
    ldst_rsp_data = data;
    @(posedge clk); #1;
    ldst_rsp_vld = 1'b0;
    checkOutput({name, " done_vld"}, done_vld, 1);
    checkOutput({name, " done_err"}, done_err, 0);
    checkReg({name, " rd value"}, rd, exp);
  endtask

  task automatic doStore(input string name, input logic [31:0] ir, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
    applyStimulus(ir);
    checkOutput({name, " addr"}, ldst_req_addr, addr);
    checkOutput({name, " wdata"}, ldst_req_wdata, wdata);
    checkOutput({name, " strb"}, ldst_req_strb, strb);
    checkOutput({name, " we"}, ldst_req_we, 1);
    @(posedge clk); #1;
    ldst_rsp_vld = 1'b1;
    @(posedge clk); #1;
    ldst_rsp_vld = 1'b0;
    checkOutput({name, " done_vld"}, done_vld, 1);
  endtask

  initial begin
    logic bad;
    rst_n = 1'b0; iexec_req_vld = 1'b0; iexec_req_ir = '0;
    ldst_req_rdy = 1'b1; ldst_rsp_vld = 1'b0; ldst_rsp_data = '0; dbg_rf_idx = '0;

    // ALU results accumulate through the table: each row relies on earlier rows.
    addVec(encI(12'd5, 0, 0, 1, OPI),               0, 1,  32'd5);
    addVec(encR(7'd0, 1, 1, 0, 2, OPR),             0, 2,  32'd10);
    addVec(encU(20'h00001, 3),                      0, 3,  32'h0000_1000);
    addVec(encI(12'd2, 3, 0, 3, OPI),               0, 3,  32'h0000_1002);
    addVec(encI(12'h0A5, 0, 0, 4, OPI),             0, 4,  32'h0000_00A5);
    addVec(encI(12'hFFF, 0, 0, 6, OPI),             0, 6,  32'hFFFF_FFFF);
    addVec(encI(12'd0, 1, 2, 7, OPI),               0, 7,  32'd0);
    addVec(encI(12'hFFF, 1, 3, 7, OPI),             0, 7,  32'd1);
    addVec(encR(7'd0, 1, 6, 3, 8, OPR),             0, 8,  32'd0);
    addVec(encR(7'd0, 1, 6, 2, 8, OPR),             0, 8,  32'd1);
    addVec(encU(20'h80000, 9),                      0, 9,  32'h8000_0000);
    addVec(encI({7'b0100000, 5'd4}, 9, 5, 10, OPI), 0, 10, 32'hF800_0000);
    addVec(encI(12'd4, 9, 5, 11, OPI),              0, 11, 32'h0800_0000);
    addVec(encI(12'd3, 1, 1, 12, OPI),              0, 12, 32'h0000_0028);
    addVec(encR(7'b0100000, 2, 1, 0, 13, OPR),      0, 13, 32'hFFFF_FFFB);
    addVec(encI(12'hFFF, 13, 4, 13, OPI),           0, 13, 32'h0000_0004);
    addVec(encR(7'b0100000, 1, 9, 5, 14, OPR),      0, 14, 32'hFC00_0000);
    addVec(encR(7'd0, 12, 4, 7, 15, OPR),           0, 15, 32'h0000_0020);
    addVec(encI(12'h101, 15, 6, 15, OPI),           0, 15, 32'h0000_0121);
    addVec(encI(12'd7, 0, 0, 0, OPI),               0, 0,  32'd0);
    addVec(encI(12'd1, 0, 0, 20, OPI),              1, 20, 32'd0);
    addVec(encI(12'd1, 17, 0, 1, OPI),              1, 1,  32'd5);
    addVec(encI(12'h021, 1, 1, 1, OPI),             1, 1,  32'd5);
    addVec(encR(7'b0100000, 1, 1, 7, 1, OPR),       1, 1,  32'd5);
    addVec(32'h0000_00FF,                           1, 1,  32'd5);
    addVec(encR(7'b0000001, 1, 1, 0, 1, OPR),       1, 1,  32'd5);
    addVec(encR(7'd0, 16, 1, 0, 2, OPR),            1, 2,  32'd10);
    addVec(encI(12'd2, 0, 2, 5, LDO),               2, 5,  32'd0);
    addVec(encS(12'd1, 4, 0, 1),                    2, 4,  32'h0000_00A5);
    addVec(encI(12'd0, 0, 3, 5, LDO),               1, 5,  32'd0);
    addVec(encS(12'd0, 4, 0, 3),                    1, 4,  32'h0000_00A5);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset iexec_req_rdy", iexec_req_rdy, 0);
    checkOutput("reset done_vld", done_vld, 0);
    checkOutput("reset ldst_req_vld", ldst_req_vld, 0);
    checkOutput("reset addr", ldst_req_addr, 0);
    checkReg("reset x1", 1, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset iexec_req_rdy", iexec_req_rdy, 1);

    // Back-to-back issue: one accept per edge.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ir);
      checkOutput($sformatf("vec%0d done_vld", i), done_vld, 1);
      checkOutput($sformatf("vec%0d done_err", i), done_err, vecs[i].err);
      checkOutput($sformatf("vec%0d ldst_req_vld", i), ldst_req_vld, 0);
      checkReg($sformatf("vec%0d rf", i), vecs[i].idx, vecs[i].val);
    end
    @(posedge clk); #1;
    checkOutput("idle no done", done_vld, 0);

    // SB x4,1(x3) with the memory stalling the request for three cycles.
    ldst_req_rdy = 1'b0;
    applyStimulus(encS(12'd1, 4, 3, 0));
    checkOutput("sb no early done", done_vld, 0);
    checkOutput("sb rdy busy", iexec_req_rdy, 0);
    checkOutput("sb we", ldst_req_we, 1);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("sb stall%0d vld", k), ldst_req_vld, 1);
      checkOutput($sformatf("sb stall%0d addr", k), ldst_req_addr, 32'h0000_1000);
      checkOutput($sformatf("sb stall%0d wdata", k), ldst_req_wdata, 32'hA5A5_A5A5);
      checkOutput($sformatf("sb stall%0d strb", k), ldst_req_strb, 4'b1000);
      @(posedge clk); #1;
    end
    ldst_req_rdy = 1'b1;
    @(posedge clk); #1;
    checkOutput("sb vld drops", ldst_req_vld, 0);
    checkOutput("sb no done in rsp", done_vld, 0);
    ldst_rsp_vld = 1'b1; ldst_rsp_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    ldst_rsp_vld = 1'b0;
    checkOutput("sb done_vld", done_vld, 1);
    checkOutput("sb done_err", done_err, 0);
    checkOutput("sb rdy back", iexec_req_rdy, 1);
    checkReg("sb x4 intact", 4, 32'h0000_00A5);
    @(posedge clk); #1;
    checkOutput("sb single pulse", done_vld, 0);

    doStore("sh", encS(12'd2, 4, 0, 1), 32'h0, 32'h00A5_00A5, 4'b1100);
    doStore("sw", encS(12'd4, 9, 0, 2), 32'h4, 32'h8000_0000, 4'b1111);

    doLoad("lh",  encI(12'd2, 0, 1, 5, LDO), 32'h0, 32'h8001_1234, 5, 32'hFFFF_8001);
    doLoad("lhu", encI(12'd2, 0, 5, 5, LDO), 32'h0, 32'h8001_1234, 5, 32'h0000_8001);
    doLoad("lb",  encI(12'd3, 0, 0, 6, LDO), 32'h0, 32'h8001_1234, 6, 32'hFFFF_FF80);
    doLoad("lbu", encI(12'd1, 0, 4, 6, LDO), 32'h0, 32'h8001_1234, 6, 32'h0000_0012);
    doLoad("lw",  encI(12'd4, 0, 2, 7, LDO), 32'h4, 32'hDEAD_BEEF, 7, 32'hDEAD_BEEF);

    // Timeout: four silent LS_RSP cycles end with err=3.
    applyStimulus(encI(12'd8, 0, 2, 7, LDO));
    checkOutput("to req_vld", ldst_req_vld, 1);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("to wait%0d done", k), done_vld, 0);
      checkOutput($sformatf("to wait%0d rdy", k), iexec_req_rdy, 0);
    end
    @(posedge clk); #1;
    checkOutput("to done_vld", done_vld, 1);
    checkOutput("to done_err", done_err, 3);
    checkOutput("to rdy back", iexec_req_rdy, 1);
    ldst_rsp_vld = 1'b1; ldst_rsp_data = 32'h0000_0055;
    @(posedge clk); #1;
    ldst_rsp_vld = 1'b0;
    checkOutput("late rsp no done", done_vld, 0);
    checkReg("late rsp x7 intact", 7, 32'hDEAD_BEEF);

    // Response arriving on the timeout cycle completes normally.
    applyStimulus(encI(12'd8, 0, 2, 7, LDO));
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) @(posedge clk);
    #1;
    checkOutput("edge rsp no early done", done_vld, 0);
    ldst_rsp_vld = 1'b1; ldst_rsp_data = 32'h1234_5678;
    @(posedge clk); #1;
    ldst_rsp_vld = 1'b0;
    checkOutput("edge rsp done_vld", done_vld, 1);
    checkOutput("edge rsp done_err", done_err, 0);
    checkReg("edge rsp x7", 7, 32'h1234_5678);

    // Reset while the request is stalled in LS_REQ.
    ldst_req_rdy = 1'b0;
    applyStimulus(encS(12'd0, 4, 0, 0));
    checkOutput("mid req_vld", ldst_req_vld, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid rst req_vld", ldst_req_vld, 0);
    checkOutput("mid rst done_vld", done_vld, 0);
    checkOutput("mid rst rdy low", iexec_req_rdy, 0);
    bad = 1'b0;
    for (int r = 1; r < 16; r++) begin
      dbg_rf_idx = 5'(r);
      #1;
      if (dbg_rf_data !== 32'd0) bad = 1'b1;
    end
    checkOutput("mid rst rf all zero", bad, 0);
    rst_n = 1'b1;
    ldst_req_rdy = 1'b1;
    #1;
    checkOutput("mid rst rdy after", iexec_req_rdy, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("mid rst quiet%0d done", k), done_vld, 0);
      checkOutput($sformatf("mid rst quiet%0d vld", k), ldst_req_vld, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/exu_mc.md
# exu_mc

Multi-cycle RV32I execute unit: the parametrised successor to the single-cycle LUI/ALU-immediate execute stage. It accepts one decoded-from-raw instruction per handshake and executes LUI, OP-IMM and OP directly into an internal register file. LOAD and STORE are issued over a valid/ready memory channel, with alignment checking, byte-lane steering and a response timeout. It sits between the fetch/issue front end and the load/store path, and reports one completion pulse per accepted instruction.

## Interface
- RF_DEPTH, 32: architectural registers; legal values are 32 (RV32I) or 16 (RV32E).
- LS_TIMEOUT, 64: maximum cycles to wait for a load/store response; 0 disables the timeout.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- iexec_req_vld  in  1  instruction valid.
- iexec_req_rdy  out  1  unit can accept; equals (state==IDLE) & rst_n.
- iexec_req_ir  in  32  raw instruction word.
- done_vld  out  1  registered one-cycle completion pulse.
- done_err  out  2  valid with done_vld: 0 ok, 1 illegal, 2 misaligned, 3 timeout.
- ldst_req_vld  out  1  memory request valid.
- ldst_req_rdy  in  1  memory accepts the request.
- ldst_req_addr  out  32  word-aligned address ({ea[31:2],2'b0}).
- ldst_req_we  out  1  1 for store.
- ldst_req_wdata  out  32  store data, lane-replicated.
- ldst_req_strb  out  4  byte enables; 4'b0000 for loads.
- ldst_rsp_vld  in  1  response valid.
- ldst_rsp_rdy  out  1  tied 1.
- ldst_rsp_data  in  32  load word.
- dbg_rf_idx  in  5  debug read index.
- dbg_rf_data  out  32  combinational read of the RF; returns 0 for x0 or for an index ≥ RF_DEPTH.

## Operation
- **Register file.** RF_DEPTH×32 flops; x0 reads 0, and writes to it are dropped. Reset clears all entries to 0.
- **FSM states.** IDLE, LS_REQ, LS_RSP.
- **IDLE accept.** An instruction is accepted when iexec_req_vld & iexec_req_rdy.
  - LUI, OP-IMM and OP write rd on the accept edge; state stays IDLE; done_vld=1 with err=0 on the next cycle.
  - LOAD/STORE: ea = rs1 + sext(imm) mod 2^32, latched together with funct3, rd and store data. State becomes LS_REQ.
- **Illegal encodings.** The following produce no RF write, err=1 on the next cycle, and state stays IDLE:
  - unsupported opcode;
  - bad funct3/funct7;
  - OP-IMM shift with ir[25]=1;
  - load funct3 ∈ {3,6,7} or store funct3 > 2;
  - any rs1/rs2/rd index ≥ RF_DEPTH.
- **Misaligned access.** Halfword with ea[0]=1, or word with ea[1:0]≠0, returns err=2 next cycle with no memory request; state stays IDLE.
- **Shifts.** Shift amount is shamt[4:0]; SRA/SRAI selected by ir[30]. SLT/SLTI are signed; SLTU/SLTIU are unsigned, with the immediate sign-extended before the compare.
- **Store lanes.**
  - SB: wdata={4{rs2[7:0]}}, strb=4'b0001<<ea[1:0].
  - SH: wdata={2{rs2[15:0]}}, strb=ea[1]?4'b1100:4'b0011.
  - SW: strb=4'b1111.
- **LS_REQ.** ldst_req_vld=1 and the payload is held stable until ldst_req_rdy; on the handshake edge the state moves to LS_RSP and the timeout counter is cleared.
- **LS_RSP.** Wait for ldst_rsp_vld.
  - On response, a load extracts its lane via ea[1:0] and sign- or zero-extends (LB/LH/LBU/LHU/LW), then writes rd.
  - A store discards the response data.
  - In both cases: done err=0, return to IDLE.
- **Timeout.** The counter increments each LS_RSP cycle without a response. If LS_TIMEOUT≠0 and the counter reaches LS_TIMEOUT−1 without a response: no RF write, err=3, return to IDLE.
- **Stale responses.** A response that arrives in IDLE or LS_REQ is ignored.

## Timing
- **Reset.** While rst_n=0 at an edge: state=IDLE, done_vld=0, done_err=0, ldst_req_vld=0, payload regs=0, RF=0, counter=0.
- **Mid-operation reset.** Reset during an operation drops the operation; no done pulse is produced.
- **ALU/LUI/error throughput.** One instruction per cycle back-to-back. A result written at edge N is visible to an instruction accepted at edge N+1. done_vld rises at cycle N+1.
- **Load/store request.** ldst_req_vld rises the cycle after acceptance, and is registered.
- **Load/store latency.** With zero-wait memory (req_rdy=1, rsp one cycle after request), the done pulse comes 3 cycles after acceptance. iexec_req_rdy=0 throughout LS_REQ and LS_RSP.
- **Response on the timeout cycle.** A response in the same cycle as the timeout limit takes priority: completion is normal.
- **done_vld.** Never asserted for two consecutive cycles on the same instruction.

## Test plan
- **ALU hazard.** Back-to-back ADDI x1,x0,5 then ADD x2,x1,x1 → dbg x2=10; done_vld high two consecutive cycles with err=0.
- **Store byte.** x3=0x1002, x4=0x000000A5, SB x4,1(x3) → addr 0x1000, strb 4'b1000, wdata 0xA5A5A5A5, we=1. With req_rdy stalled for 3 cycles, the payload stays stable.
- **Load halfword sign-extend.** LH x5,2(x0), rsp_data 0x8001_1234 → x5=0xFFFF8001. LHU of the same → 0x00008001.
- **Misaligned and illegal.** LW at ea=0x2 → err=2, no ldst_req_vld. With RF_DEPTH=16, ADDI x20,x0,1 → err=1, x20 unmodified.
- **Timeout.** LS_TIMEOUT=4 with no response → err=3 and return to IDLE after 4 LS_RSP cycles. A late rsp_vld afterwards is ignored and the RF is unchanged.
- **Reset mid-operation.** Assert rst_n=0 in LS_REQ → next cycle ldst_req_vld=0, RF all zeros, iexec_req_rdy=1 after release, no done pulse.
